// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal register: hold, shift, rotate, parallel load, clear and invert, with a saturating shift counter.
// Define USR_NEG_EDGE_CLK_EN to make all registers capture on the falling clock edge.
module universal_shift_reg_n #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      CNT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset_b,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] NQ,
   output logic             sout_msb,
   output logic             sout_lsb,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             full_shift
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_SHR  = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_INV  = 3'b111
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   mode_e            op;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt;
   logic             is_shift;

   assign op = mode_e'(mode);

   always_comb begin
      q_nxt    = q_r;
      cnt_nxt  = cnt_r;
      is_shift = 1'b0;
      case (op)
         MODE_HOLD: ;
         MODE_SHR: begin
            q_nxt    = {sin_msb, q_r[WIDTH-1:1]};
            is_shift = 1'b1;
         end
         MODE_SHL: begin
            q_nxt    = {q_r[WIDTH-2:0], sin_lsb};
            is_shift = 1'b1;
         end
         MODE_LOAD: begin
            q_nxt   = D;
            cnt_nxt = '0;
         end
         MODE_ROR: begin
            q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
            is_shift = 1'b1;
         end
         MODE_ROL: begin
            q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            is_shift = 1'b1;
         end
         MODE_CLR: begin
            q_nxt   = '0;
            cnt_nxt = '0;
         end
         MODE_INV: q_nxt = ~q_r;
         default: ;
      endcase
      // Counter saturates at WIDTH so full_shift stays asserted on further shifts.
      if (is_shift && (cnt_r != CNT_MAX))
         cnt_nxt = cnt_r + CNT_W'(1);
   end

`ifdef USR_NEG_EDGE_CLK_EN
   always_ff @(negedge clock or negedge reset_b) begin
`else
   always_ff @(posedge clock or negedge reset_b) begin
`endif
      if (!reset_b) begin
         q_r   <= RESET_VAL;
         cnt_r <= '0;
      end else if (en) begin
         q_r   <= q_nxt;
         cnt_r <= cnt_nxt;
      end
   end

   assign Q          = q_r;
   assign NQ         = ~q_r;
   assign sout_msb   = q_r[WIDTH-1];
   assign sout_lsb   = q_r[0];
   assign shift_cnt  = cnt_r;
   assign full_shift = (cnt_r == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Scoreboard bench for universal_shift_reg_n: driver pushes model predictions, monitor pops on every active edge.
// Works for both clock-edge builds (USR_NEG_EDGE_CLK_EN).
`timescale 1ns/1ps
module tb_universal_shift_reg_n;

   localparam int unsigned W    = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned MASK = (1 << W) - 1;
`ifdef USR_NEG_EDGE_CLK_EN
   localparam bit NEG = 1'b1;
`else
   localparam bit NEG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clk_run = 1'b0;
   logic          reset_b;
   logic          en;
   logic [2:0]    mode;
   logic [W-1:0]  d;
   logic          sin_msb;
   logic          sin_lsb;
   logic [W-1:0]  q;
   logic [W-1:0]  nq;
   logic          sout_msb;
   logic          sout_lsb;
   logic [CW-1:0] shift_cnt;
   logic          full_shift;

   typedef struct {
      int unsigned q;
      int unsigned cnt;
   } exp_t;

   exp_t        sb[$];
   int unsigned m_q;
   int unsigned m_cnt;
   int          checks   = 0;
   int          failures = 0;

   universal_shift_reg_n #(.WIDTH(W), .CNT_W(CW), .RESET_VAL(8'h00)) dut (
      .clock(clk), .reset_b(reset_b), .en(en), .mode(mode), .D(d),
      .sin_msb(sin_msb), .sin_lsb(sin_lsb), .Q(q), .NQ(nq),
      .sout_msb(sout_msb), .sout_lsb(sout_lsb),
      .shift_cnt(shift_cnt), .full_shift(full_shift)
   );

   always #10 if (clk_run) clk = ~clk;

   task automatic wait_active();
      if (NEG) @(negedge clk);
      else     @(posedge clk);
   endtask

   task automatic wait_idle();
      if (NEG) @(posedge clk);
      else     @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input int unsigned eq, input int unsigned ecnt);
      chk({name, ".Q"}, 32'(q), eq);
      chk({name, ".NQ"}, 32'(nq), (~eq) & MASK);
      chk({name, ".sout_msb"}, 32'(sout_msb), (eq >> (W - 1)) & 1);
      chk({name, ".sout_lsb"}, 32'(sout_lsb), eq & 1);
      chk({name, ".shift_cnt"}, 32'(shift_cnt), ecnt);
      chk({name, ".full_shift"}, 32'(full_shift), (ecnt == W) ? 1 : 0);
   endtask

   // Reference: next state from the mode rules using plain integer arithmetic.
   function automatic void model_step(input bit e, input int unsigned md, input int unsigned dv,
                                      input bit sm, input bit sl);
      int unsigned nq_v;
      bit          shifted;
      if (!e) return;
      nq_v    = m_q;
      shifted = 1'b0;
      case (md)
         1: begin nq_v = (m_q / 2) + (sm ? (1 << (W - 1)) : 0); shifted = 1; end
         2: begin nq_v = ((m_q * 2) % (1 << W)) + (sl ? 1 : 0); shifted = 1; end
         3: begin nq_v = dv; m_cnt = 0; end
         4: begin nq_v = (m_q / 2) + ((m_q % 2) << (W - 1)); shifted = 1; end
         5: begin nq_v = ((m_q * 2) % (1 << W)) + (m_q >> (W - 1)); shifted = 1; end
         6: begin nq_v = 0; m_cnt = 0; end
         7: nq_v = MASK - m_q;
         default: ;
      endcase
      if (shifted && m_cnt < W) m_cnt++;
      m_q = nq_v;
   endfunction

   task automatic step(input bit e, input logic [2:0] md, input logic [W-1:0] dv,
                       input bit sm, input bit sl);
      exp_t x;
      wait_idle();
      chk("stable_between_edges", 32'(q), m_q);
      en = e; mode = md; d = dv; sin_msb = sm; sin_lsb = sl;
      model_step(e, md, dv, sm, sl);
      x.q = m_q; x.cnt = m_cnt;
      sb.push_back(x);
      wait_active();
      #3;
      en = 1'b1; mode = 3'($urandom); d = W'($urandom);
      sin_msb = 1'($urandom); sin_lsb = 1'($urandom);
      #1;
      en = 1'b0;
   endtask

   task automatic async_reset(input string name);
      reset_b = 1'b0;
      #1;
      m_q = 0; m_cnt = 0;
      chk_all(name, 8'h00, 0);
      reset_b = 1'b1;
   endtask

   always begin
      exp_t e;
      wait_active();
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_all("edge", e.q, e.cnt);
      end
   end

   initial begin
      reset_b = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sin_msb = 1'b0; sin_lsb = 1'b0;
      m_q = 0; m_cnt = 0;
      #5;
      async_reset("reset_no_clock");
      #6;
      clk_run = 1'b1;

      step(1, 3'b011, 8'hA5, 0, 0);
      chk_all("load_a5", 8'hA5, 0);
      d = 8'h3C;
      #2;
      chk("d_change_between_edges", 32'(q), 8'hA5);

      for (int i = 0; i < 8; i++) step(1, 3'b001, 8'h00, 1, 0);
      chk_all("shr_full", 8'hFF, 8);
      step(1, 3'b001, 8'h00, 1, 0);
      chk_all("shr_saturate", 8'hFF, 8);

      step(1, 3'b011, 8'h81, 0, 0);
      step(1, 3'b101, 8'h00, 0, 0);
      chk_all("rol_81", 8'h03, 1);
      step(1, 3'b100, 8'h00, 0, 0);
      step(1, 3'b100, 8'h00, 0, 0);
      chk_all("ror_twice", 8'hC0, 3);

      step(1, 3'b011, 8'h0F, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 3'b111, 8'h00, 0, 0);
      chk_all("inv_disabled", 8'h0F, 0);
      step(1, 3'b111, 8'h00, 0, 0);
      chk_all("inv_enabled", 8'hF0, 0);
      step(1, 3'b010, 8'h00, 0, 1);
      step(1, 3'b110, 8'h00, 0, 0);
      chk_all("sync_clear", 8'h00, 0);

      step(1, 3'b011, 8'h5A, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 3'b010, 8'h00, 0, 1);
      chk_all("shl_three", 8'hD7, 3);
      async_reset("reset_mid_sequence");

      for (int i = 0; i < 300; i++) begin
         logic [2:0] md;
         md = 3'($urandom);
         step(($urandom_range(0, 7) != 0), md, W'($urandom), 1'($urandom), 1'($urandom));
         if (i == 150) async_reset("reset_random");
      end

      for (int i = 0; i < 4 && sb.size() > 0; i++) wait_active();
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/universal_shift_reg_n.md
Name: universal_shift_reg_n

Overview:
- Parametrised N-bit edge-triggered storage register. It is the next generation of the team's single-bit D flip-flop and is built from the same flip-flop semantics, widened to WIDTH bits.
- Adds the following operating modes: hold, shift, rotate, parallel load, synchronous clear and invert.
- Includes a shift-progress counter, so the block can serve as a serialiser/deserialiser or a general datapath register in later labs.
- Provides true and complemented outputs (Q/NQ pair).

Parameters:
- WIDTH, 8, register width in bits (minimum 2).
- CNT_W, 4, width of shift_cnt; must satisfy 2^CNT_W > WIDTH.
- RESET_VAL, 0, value loaded into Q on reset (WIDTH bits).

Ports:
- clock  input  1  system clock; active edge is rising by default (see Optional Feature).
- reset_b  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when 0 all state holds regardless of mode.
- mode  input  3  operation select (encoding in Behaviour).
- D  input  WIDTH  parallel load data.
- sin_msb  input  1  serial input entering at bit WIDTH-1 on shift right.
- sin_lsb  input  1  serial input entering at bit 0 on shift left.
- Q  output  WIDTH  register contents.
- NQ  output  WIDTH  bitwise complement of Q; combinational from Q, never registered separately.
- sout_msb  output  1  equals Q[WIDTH-1].
- sout_lsb  output  1  equals Q[0].
- shift_cnt  output  CNT_W  number of shift/rotate operations since the last load, clear or reset.
- full_shift  output  1  high while shift_cnt == WIDTH.

Behaviour:
- Reset (reset_b=0): immediately, with no clock required.
  - Q=RESET_VAL, NQ=~RESET_VAL, shift_cnt=0, full_shift=0.
  - Reset dominates en and mode.
  - Deassertion takes effect at the next active edge.
- All updates occur on the active clock edge only when en=1. Latency is 1 edge: the new Q is visible after that edge.
- mode encoding:
  - 000 hold: Q unchanged; shift_cnt unchanged.
  - 001 shift right: Q <= {sin_msb, Q[WIDTH-1:1]}.
  - 010 shift left: Q <= {Q[WIDTH-2:0], sin_lsb}.
  - 011 parallel load: Q <= D; shift_cnt <= 0.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}.
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - 110 synchronous clear: Q <= 0 (not RESET_VAL); shift_cnt <= 0.
  - 111 invert: Q <= ~Q; shift_cnt unchanged.
- shift_cnt behaviour:
  - Increments by 1 on each enabled shift or rotate (modes 001, 010, 100, 101).
  - Saturates at WIDTH; no wrap-around.
  - Further shifts keep it at WIDTH and full_shift stays 1.
  - full_shift is decoded combinationally from shift_cnt.
- Serial inputs are sampled only on the edge where the corresponding shift mode is active. sin_msb and sin_lsb are ignored in every other mode.
- Changes on D, mode, sin_* or en between active edges have no effect on Q. This is the same edge-capture rule as the single-bit flip-flop.
- Reset asserted mid-sequence (e.g. after 3 shifts) returns shift_cnt to 0 and Q to RESET_VAL at once. The sequence restarts from scratch.
- Unknown (X) mode values are not required to be handled; the bench never drives them.

Optional Feature:
- Macro: USR_NEG_EDGE_CLK_EN.
- Defined: every register in the block (Q, shift_cnt) captures on the falling edge of clock, matching the negative-edge flip-flop behaviour. The asynchronous reset is unchanged.
- Undefined: every register captures on the rising edge of clock.
- Port list, mode encoding and latency (one active edge) are identical in both builds.

Test Plan:
1. WIDTH=8. Assert reset_b=0 at t=5 with the clock stopped -> Q=8'h00, NQ=8'hFF and shift_cnt=0 immediately, before any clock edge.
2. mode=011, D=8'hA5, en=1, one active edge -> Q=8'hA5, NQ=8'h5A, shift_cnt=0. Change D to 8'h3C between edges -> Q stays 8'hA5.
3. From Q=8'hA5: mode=001 with sin_msb=1 for 8 edges -> Q=8'hFF, shift_cnt=8, full_shift=1. A 9th shift -> shift_cnt stays 8.
4. From Q=8'h81: mode=101 for 1 edge -> Q=8'h03. Then mode=100 for 2 edges -> Q=8'hC0. shift_cnt=3, full_shift=0.
5. Q=8'h0F, mode=111, en=0 for 3 edges -> Q stays 8'h0F. Set en=1 for 1 edge -> Q=8'hF0. Then mode=110 for 1 edge -> Q=8'h00, shift_cnt=0.
6. Build with USR_NEG_EDGE_CLK_EN defined, clock starting at 1 with period 40. Load 8'h5A while clock is high -> Q changes only at the next falling edge (t=20), not at the rising edge. Pull reset_b low after 3 shifts -> Q=RESET_VAL and shift_cnt=0 immediately.
